// File: rtl/which_note.sv
// which_note: monophonic pitch detector, square-wave period -> nearest MIDI note (21..108).
// Define GLITCH_FILTER_EN to add a GLITCH_CYCLES-wide deglitch filter after the synchronizer.
module which_note #(
    parameter int F_CLK         = 12_000_000,
    parameter int STABLE_COUNT  = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audio,
    output logic [6:0] midi,
    output logic       note_on
);
    function automatic int bnd(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.5) / 12.0));
        return $rtoi(real'(F_CLK) / f + 0.5);
    endfunction

    localparam int MAX_P = bnd(21);
    localparam int MIN_P = bnd(109);
    localparam int CW    = $clog2(MAX_P + 2);
    localparam int SW    = $clog2(STABLE_COUNT + 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    logic [CW-1:0] w_rom [0:88];
    for (genvar k = 0; k < 89; k++) begin : g_rom
        localparam logic [CW-1:0] B = CW'(bnd(21 + k));
        assign w_rom[k] = B;
    end

    logic [1:0]    r_sync;
    logic          r_prev, r_armed;
    logic [CW-1:0] r_cnt, r_per;
    state_t        r_state;
    logic [6:0]    r_k, r_cand;
    logic [SW-1:0] r_stab;
    logic          w_in, w_edge, w_cap, w_tout, w_ok, w_hit, w_same;
    logic [6:0]    w_k1, w_n;
    logic [SW-1:0] w_nc;

`ifdef GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic          r_filt;
    logic [GW-1:0] r_gcnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= 1'b0;
            r_gcnt <= '0;
        end else if (r_sync[1] == r_filt) begin
            r_gcnt <= '0;
        end else if (r_gcnt == GW'(GLITCH_CYCLES - 1)) begin
            r_filt <= r_sync[1];
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + GW'(1);
        end
    end
    assign w_in = r_filt;
`else
    localparam int unused_glitch = GLITCH_CYCLES;
    assign w_in = r_sync[1];
`endif

    assign w_edge = w_in & ~r_prev;
    assign w_cap  = w_edge & r_armed;
    assign w_tout = r_armed & ~w_edge & (r_cnt == CW'(MAX_P + 1));
    assign w_ok   = (r_cnt > CW'(MIN_P)) && (r_cnt <= CW'(MAX_P));
    assign w_k1   = r_k + 7'd1;
    // Table is descending, so the first boundary below the period names the note.
    assign w_hit  = (r_state == SEARCH) && (r_per > w_rom[w_k1]);
    assign w_n    = 7'd21 + r_k;
    assign w_same = (w_n == r_cand);
    assign w_nc   = w_same ? ((r_stab == SW'(STABLE_COUNT)) ? r_stab : r_stab + SW'(1)) : SW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_per   <= '0;
            r_state <= IDLE;
            r_k     <= '0;
            r_cand  <= '0;
            r_stab  <= '0;
            midi    <= '0;
            note_on <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], audio};
            r_prev  <= w_in;
            r_cnt   <= w_edge ? CW'(1) : (r_cnt == CW'(MAX_P + 1)) ? r_cnt : r_cnt + CW'(1);
            r_armed <= w_edge | (r_armed & ~w_tout);
            if ((w_cap && (r_state == SEARCH || !w_ok)) || w_tout) begin
                r_state <= IDLE;
                r_stab  <= '0;
                note_on <= 1'b0;
            end else if (w_cap) begin
                r_per   <= r_cnt;
                r_k     <= '0;
                r_state <= SEARCH;
            end else if (w_hit) begin
                r_state <= IDLE;
                r_cand  <= w_n;
                r_stab  <= w_nc;
                if (w_nc == SW'(STABLE_COUNT)) begin
                    midi    <= w_n;
                    note_on <= 1'b1;
                end
            end else if (r_state == SEARCH) begin
                r_k <= w_k1;
            end
        end
    end
endmodule

// File: tb/tb_which_note.sv
// tb_which_note: directed vectors and corner-case sequences for which_note at F_CLK = 480 kHz.
module tb_which_note;
    localparam int MAX_P = 17966;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       audio = 1'b0;
    logic [6:0] midi;
    logic       note_on;

    int n_err = 0;
    int n_chk = 0;

    logic       mon_en = 1'b0;
    logic       mon_on = 1'b0;
    logic [6:0] mon_a = '0, mon_b = '0;
    int         mon_bad = 0;

    which_note #(.F_CLK(480_000)) dut (
        .clk(clk), .reset(reset), .audio(audio), .midi(midi), .note_on(note_on)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && (note_on !== mon_on || (mon_on && midi !== mon_a && midi !== mon_b)))
            mon_bad++;

    typedef struct {
        int         per;
        logic [6:0] midi;
        logic       on;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        audio = 1'b0;
        clocks(5);
        reset = 1'b0;
        clocks(1);
    endtask

    task automatic wave(input int p, input int n);
        repeat (n) begin
            audio = 1'b1;
            clocks(p / 2);
            audio = 1'b0;
            clocks(p - p / 2);
        end
    endtask

    initial begin
        vec_t vt[8];
        int   b0, el;
        vt[0] = '{917,  7'd72,  1'b1};
        vt[1] = '{273,  7'd93,  1'b1};
        vt[2] = '{182,  7'd100, 1'b1};
        vt[3] = '{1835, 7'd60,  1'b1};
        vt[4] = '{112,  7'd108, 1'b1};
        vt[5] = '{115,  7'd108, 1'b1};
        vt[6] = '{111,  7'd0,   1'b0};
        vt[7] = '{96,   7'd0,   1'b0};

        clocks(3);
        chk("in_reset_note_on", note_on, 0);
        chk("in_reset_midi", midi, 0);
        clocks(2);
        reset = 1'b0;
        clocks(480);
        chk("idle_note_on", note_on, 0);
        chk("idle_midi", midi, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            wave(vt[i].per, 2);
            chk($sformatf("p%0d_one_period_on", vt[i].per), note_on, 0);
            wave(vt[i].per, 3);
            chk($sformatf("p%0d_on", vt[i].per), note_on, vt[i].on);
            chk($sformatf("p%0d_midi", vt[i].per), midi, vt[i].midi);
        end

        do_reset();
        wave(1091, 3);
        chk("a440_on", note_on, 1);
        chk("a440_midi", midi, 69);
        b0 = mon_bad; mon_on = 1'b1; mon_a = 7'd69; mon_b = 7'd69; mon_en = 1'b1;
        wave(1091, 8);
        mon_en = 1'b0;
        chk("a440_hold_glitches", mon_bad - b0, 0);

        do_reset();
        wave(1835, 3);
        chk("c4_midi", midi, 60);
        b0 = mon_bad; mon_on = 1'b1; mon_a = 7'd60; mon_b = 7'd72; mon_en = 1'b1;
        wave(917, 2);
        chk("step_not_yet", midi, 60);
        wave(917, 1);
        chk("step_c5_midi", midi, 72);
        mon_en = 1'b0;
        chk("step_intermediate", mon_bad - b0, 0);

        do_reset();
        wave(1091, 3);
        audio = 1'b1;
        clocks(MAX_P - 10);
        chk("stop_still_on", note_on, 1);
        el = MAX_P - 10;
        while (note_on === 1'b1 && el < MAX_P + 12) begin
            clocks(1);
            el++;
        end
        chk("stop_timeout_off", note_on, 0);
        chk("stop_midi_hold", midi, 69);
        b0 = mon_bad; mon_on = 1'b0; mon_en = 1'b1;
        audio = 1'b0;
        clocks(1000);
        audio = 1'b1;
        clocks(500);
        audio = 1'b0;
        clocks(500);
        mon_en = 1'b0;
        chk("slow_stays_off", mon_bad - b0, 0);

        do_reset();
        wave(1091, 3);
        chk("pre_reset_on", note_on, 1);
        reset = 1'b1;
        clocks(1);
        chk("midreset_on", note_on, 0);
        chk("midreset_midi", midi, 0);
        reset = 1'b0;
        wave(1091, 2);
        chk("rearm_not_yet", note_on, 0);
        wave(1091, 1);
        chk("rearm_on", note_on, 1);
        chk("rearm_midi", midi, 69);

        do_reset();
        repeat (6) begin
            audio = 1'b1;
            clocks(20);
            audio = 1'b0;
            clocks(1);
            audio = 1'b1;
            clocks(525);
            audio = 1'b0;
            clocks(545);
        end
`ifdef GLITCH_FILTER_EN
        chk("spike_on", note_on, 1);
        chk("spike_midi", midi, 69);
`else
        chk("spike_on", note_on, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
